// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM encoding, counter widths
// and the frame-length clamp applied when a word is captured.
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int GAP_W = 4;

   // A length of zero, or one beyond the word width, means a full-width frame.
   function automatic int clamp_len(input int len, input int data_w);
      return ((len == 0) || (len > data_w)) ? data_w : len;
   endfunction

endpackage

// File: rtl/bit_serializer_word_buffer.sv
// One-entry holding register with a valid flag, so the next word can be
// accepted while the current one is being shifted out.
module word_buffer #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic [LEN_W-1:0]  len_in,
   output logic [DATA_W-1:0] data,
   output logic [LEN_W-1:0]  len,
   output logic              full
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
         len  <= '0;
         full <= 1'b0;
      end else if (push) begin
         data <= data_in;
         len  <= len_in;
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Serializes parallel words into a direction-bit stream for the downstream
// ring-counter sequence FSM, with per-word frame length and a fixed idle gap.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 4,
   parameter int MSB_FIRST  = 0,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic [LEN_W-1:0]  din_len,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              hold,
   output logic              a_out,
   output logic              a_valid,
   output logic              frame_done,
   output logic              busy
);

   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);

   state_t              state;
   logic [DATA_W-1:0]   shift_reg;
   logic [LEN_W-1:0]    bit_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                frame_done_r;

   logic [DATA_W-1:0]   buf_data;
   logic [LEN_W-1:0]    buf_len;
   logic                buf_full;
   logic                push;
   logic                pop;
   logic [LEN_W-1:0]    len_clamped;
   logic                last_bit;
   logic                gap_last;

   // Handshake: a word transfers on a rising edge where din_valid && din_ready;
   // din_ready depends only on the buffer flag, never on din_valid.
   assign din_ready   = !buf_full;
   assign push        = din_valid && !buf_full;
   assign len_clamped = LEN_W'(clamp_len(int'(din_len), DATA_W));
   assign last_bit    = (bit_cnt == LEN_W'(1));
   assign gap_last    = (gap_cnt <= GAP_W'(1));

   // The buffer is drained whenever the shifter is about to take a new word.
   always_comb begin
      pop = 1'b0;
      if (buf_full) begin
         case (state)
            IDLE:    pop = 1'b1;
            SHIFT:   pop = !hold && last_bit && (GAP_CYCLES == 0);
            GAP:     pop = gap_last;
            default: pop = 1'b0;
         endcase
      end
   end

   word_buffer #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_word_buffer (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .data_in (din),
      .len_in  (len_clamped),
      .data    (buf_data),
      .len     (buf_len),
      .full    (buf_full)
   );

   // MSB-first frames are left-justified so the next bit is always the top bit.
   function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] d,
                                                input logic [LEN_W-1:0]  l);
      if (MSB_FIRST != 0) return d << (DATA_W - int'(l));
      else                return d;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         gap_cnt      <= '0;
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  shift_reg <= align(buf_data, buf_len);
                  bit_cnt   <= buf_len;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (!hold) begin
                  if (last_bit) begin
                     frame_done_r <= 1'b1;
                     if (pop) begin
                        shift_reg <= align(buf_data, buf_len);
                        bit_cnt   <= buf_len;
                     end else if (GAP_CYCLES > 0) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        gap_cnt   <= GAP_INIT;
                        state     <= GAP;
                     end else begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                     end
                  end else begin
                     if (MSB_FIRST != 0) shift_reg <= shift_reg << 1;
                     else                shift_reg <= shift_reg >> 1;
                     bit_cnt <= bit_cnt - LEN_W'(1);
                  end
               end
            end
            GAP: begin
               // The idle gap runs on regardless of hold.
               if (gap_last) begin
                  gap_cnt <= '0;
                  if (pop) begin
                     shift_reg <= align(buf_data, buf_len);
                     bit_cnt   <= buf_len;
                     state     <= SHIFT;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign a_valid    = (state == SHIFT);
   assign a_out      = (state == SHIFT) ? ((MSB_FIRST != 0) ? shift_reg[DATA_W-1] : shift_reg[0])
                                        : 1'b0;
   assign frame_done = frame_done_r;
   assign busy       = (state != IDLE) || buf_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (LSB-first, MSB-first, LSB-first
// with a 2-cycle gap) driven by a vector table plus hand-written sequences.
module tb_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic [3:0] din_len;
   logic       hold;
   logic [2:0] din_valid_v;
   logic [2:0] din_ready_v;
   logic [2:0] a_out_v;
   logic [2:0] a_valid_v;
   logic [2:0] frame_done_v;
   logic [2:0] busy_v;

   int total_cnt;
   int pass_cnt;

   typedef struct {
      int         dut;
      logic [7:0] din;
      logic [3:0] len;
      int         nbits;
      logic [7:0] seq;
      string      name;
   } vec_t;

   vec_t vecs[9];

   bit_serializer #(.DATA_W(8), .LEN_W(4), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_len(din_len), .din_valid(din_valid_v[0]),
      .din_ready(din_ready_v[0]), .hold(hold), .a_out(a_out_v[0]), .a_valid(a_valid_v[0]),
      .frame_done(frame_done_v[0]), .busy(busy_v[0])
   );

   bit_serializer #(.DATA_W(8), .LEN_W(4), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_msb (
      .clk(clk), .rst(rst), .din(din), .din_len(din_len), .din_valid(din_valid_v[1]),
      .din_ready(din_ready_v[1]), .hold(hold), .a_out(a_out_v[1]), .a_valid(a_valid_v[1]),
      .frame_done(frame_done_v[1]), .busy(busy_v[1])
   );

   bit_serializer #(.DATA_W(8), .LEN_W(4), .MSB_FIRST(0), .GAP_CYCLES(2)) dut_gap (
      .clk(clk), .rst(rst), .din(din), .din_len(din_len), .din_valid(din_valid_v[2]),
      .din_ready(din_ready_v[2]), .hold(hold), .a_out(a_out_v[2]), .a_valid(a_valid_v[2]),
      .frame_done(frame_done_v[2]), .busy(busy_v[2])
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else pass_cnt++;
   endtask

   // One sample: expected a_valid / a_out / frame_done on instance k.
   task automatic expect_out(input string nm, input int k, input logic av, input logic ao,
                             input logic fd);
      check({nm, "_valid"}, a_valid_v[k], av);
      check({nm, "_bit"}, a_out_v[k], ao);
      check({nm, "_done"}, frame_done_v[k], fd);
   endtask

   task automatic run_frame(input int k, input logic [7:0] d, input logic [3:0] l,
                            input int n, input logic [7:0] seq, input string nm);
      check({nm, "_ready"}, din_ready_v[k], 1'b1);
      din = d;
      din_len = l;
      din_valid_v[k] = 1'b1;
      step();
      din_valid_v[k] = 1'b0;
      check({nm, "_latency"}, a_valid_v[k], 1'b0);
      for (int i = 0; i < n; i++) begin
         step();
         expect_out($sformatf("%s_b%0d", nm, i), k, 1'b1, seq[i], 1'b0);
      end
      step();
      check({nm, "_end_valid"}, a_valid_v[k], 1'b0);
      check({nm, "_end_done"}, frame_done_v[k], 1'b1);
      repeat (3) step();
      check({nm, "_idle_busy"}, busy_v[k], 1'b0);
      check({nm, "_idle_done"}, frame_done_v[k], 1'b0);
   endtask

   initial begin
      total_cnt   = 0;
      pass_cnt    = 0;
      rst         = 1'b0;
      hold        = 1'b0;
      din         = '0;
      din_len     = '0;
      din_valid_v = '0;

      vecs[0] = '{0, 8'hB2, 4'd8,  8, 8'hB2, "lsb_b2_len8"};
      vecs[1] = '{0, 8'hFF, 4'd3,  3, 8'h07, "lsb_ff_len3"};
      vecs[2] = '{0, 8'hA5, 4'd0,  8, 8'hA5, "lsb_len0"};
      vecs[3] = '{0, 8'h3C, 4'd12, 8, 8'h3C, "lsb_len12"};
      vecs[4] = '{0, 8'h5A, 4'd1,  1, 8'h00, "lsb_len1"};
      vecs[5] = '{1, 8'h04, 4'd3,  3, 8'h01, "msb_len3"};
      vecs[6] = '{1, 8'hB2, 4'd8,  8, 8'h4D, "msb_len8"};
      vecs[7] = '{1, 8'hF6, 4'd5,  5, 8'h0D, "msb_len5"};
      vecs[8] = '{2, 8'h02, 4'd2,  2, 8'h02, "gap_len2"};

      // Reset asserted mid-cycle: outputs clear without waiting for an edge.
      #13;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst%0d_a_out", k), a_out_v[k], 1'b0);
         check($sformatf("rst%0d_a_valid", k), a_valid_v[k], 1'b0);
         check($sformatf("rst%0d_done", k), frame_done_v[k], 1'b0);
         check($sformatf("rst%0d_busy", k), busy_v[k], 1'b0);
         check($sformatf("rst%0d_ready", k), din_ready_v[k], 1'b1);
      end
      step();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check($sformatf("idle_c%0d", c), a_valid_v, 3'b000);
      end

      for (int v = 0; v < 9; v++)
         run_frame(vecs[v].dut, vecs[v].din, vecs[v].len, vecs[v].nbits, vecs[v].seq,
                   vecs[v].name);

      // Back-to-back len=4 words with a 3-cycle stall on bit 2.
      din = 8'h0A; din_len = 4'd4; din_valid_v[0] = 1'b1;
      step();
      check("b2b_lat", a_valid_v[0], 1'b0);
      check("b2b_full0", din_ready_v[0], 1'b0);
      din = 8'h06;
      step();
      expect_out("b2b_w1b0", 0, 1'b1, 1'b0, 1'b0);
      check("b2b_ready1", din_ready_v[0], 1'b1);
      step();
      din_valid_v[0] = 1'b0;
      expect_out("b2b_w1b1", 0, 1'b1, 1'b1, 1'b0);
      check("b2b_full1", din_ready_v[0], 1'b0);
      step();
      expect_out("b2b_w1b2", 0, 1'b1, 1'b0, 1'b0);
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         expect_out($sformatf("b2b_hold%0d", c), 0, 1'b1, 1'b0, 1'b0);
         check($sformatf("b2b_hold_ready%0d", c), din_ready_v[0], 1'b0);
      end
      hold = 1'b0;
      step();
      expect_out("b2b_w1b3", 0, 1'b1, 1'b1, 1'b0);
      step();
      expect_out("b2b_w2b0", 0, 1'b1, 1'b0, 1'b1);
      check("b2b_ready2", din_ready_v[0], 1'b1);
      step();
      expect_out("b2b_w2b1", 0, 1'b1, 1'b1, 1'b0);
      step();
      expect_out("b2b_w2b2", 0, 1'b1, 1'b1, 1'b0);
      step();
      expect_out("b2b_w2b3", 0, 1'b1, 1'b0, 1'b0);
      step();
      expect_out("b2b_end", 0, 1'b0, 1'b0, 1'b1);
      repeat (2) step();
      check("b2b_busy", busy_v[0], 1'b0);

      // Two len=2 frames through the 2-cycle gap instance.
      din = 8'h01; din_len = 4'd2; din_valid_v[2] = 1'b1;
      step();
      check("gap_lat", a_valid_v[2], 1'b0);
      din = 8'h03;
      step();
      expect_out("gap_f1b0", 2, 1'b1, 1'b1, 1'b0);
      step();
      din_valid_v[2] = 1'b0;
      expect_out("gap_f1b1", 2, 1'b1, 1'b0, 1'b0);
      step();
      expect_out("gap_idle0", 2, 1'b0, 1'b0, 1'b1);
      check("gap_busy_gap", busy_v[2], 1'b1);
      step();
      expect_out("gap_idle1", 2, 1'b0, 1'b0, 1'b0);
      step();
      expect_out("gap_f2b0", 2, 1'b1, 1'b1, 1'b0);
      step();
      expect_out("gap_f2b1", 2, 1'b1, 1'b1, 1'b0);
      step();
      expect_out("gap_end", 2, 1'b0, 1'b0, 1'b1);
      repeat (2) step();
      check("gap_busy_end", busy_v[2], 1'b0);

      // Reset during bit 5 of 8 with a second word buffered.
      din = 8'hFF; din_len = 4'd8; din_valid_v[0] = 1'b1;
      step();
      din = 8'h81;
      step();
      step();
      din_valid_v[0] = 1'b0;
      check("rmid_full", din_ready_v[0], 1'b0);
      repeat (3) step();
      expect_out("rmid_b4", 0, 1'b1, 1'b1, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      expect_out("rmid_async", 0, 1'b0, 1'b0, 1'b0);
      check("rmid_busy", busy_v[0], 1'b0);
      check("rmid_ready", din_ready_v[0], 1'b1);
      for (int c = 0; c < 2; c++) begin
         step();
         check($sformatf("rmid_done_in_rst%0d", c), frame_done_v[0], 1'b0);
      end
      rst = 1'b0;
      step();
      expect_out("rmid_after", 0, 1'b0, 1'b0, 1'b0);
      check("rmid_after_busy", busy_v[0], 1'b0);
      run_frame(0, 8'h01, 4'd8, 8, 8'h01, "rmid_next");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
